// File: rtl/sccb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sccb_pkg
// Brief    : Shared widths, default device ID and FSM state type for the
//            SCCB responder.
// Revision : 1.0
// ============================================================================
package sccb_pkg;

    localparam int SCCB_ID_W   = 7;
    localparam int SCCB_SUB_W  = 16;
    localparam int SCCB_DATA_W = 8;

    localparam logic [SCCB_ID_W-1:0] SCCB_DEF_ID = 7'h3C;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV       = 4'd1,
        ST_DEV_ACK   = 4'd2,
        ST_SUB_H     = 4'd3,
        ST_SUB_H_ACK = 4'd4,
        ST_SUB_L     = 4'd5,
        ST_SUB_L_ACK = 4'd6,
        ST_WDATA     = 4'd7,
        ST_WDATA_ACK = 4'd8,
        ST_RDATA     = 4'd9,
        ST_RDATA_ACK = 4'd10,
        ST_IGNORE    = 4'd11
    } sccb_state_t;

endpackage
`default_nettype wire

// File: rtl/sccb_line_filter.sv
`default_nettype none
// ============================================================================
// Module   : sccb_line_filter
// Brief    : Two-flop synchronizer, FILT_LEN-sample glitch filter and
//            registered rise/fall pulses for one SCCB line.
// Revision : 1.0
// ============================================================================
module sccb_line_filter
    import sccb_pkg::*;
#(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic nrst,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_s1;
    logic r_s2;
    logic r_level;
    logic r_rise;
    logic r_fall;
    logic w_all_hi;
    logic w_all_lo;

    // Lines idle high (pull-ups), so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= pad;
            r_s2 <= r_s1;
        end
    end

    generate
        if (FILT_LEN > 1) begin : g_hist
            logic [FILT_LEN-2:0] r_hist;
            logic [FILT_LEN-1:0] w_win;

            assign w_win    = {r_hist, r_s2};
            assign w_all_hi = &w_win;
            assign w_all_lo = ~|w_win;

            always_ff @(posedge clk) begin
                if (!nrst) begin
                    r_hist <= '1;
                end else begin
                    r_hist <= w_win[FILT_LEN-2:0];
                end
            end
        end else begin : g_nohist
            assign w_all_hi = r_s2;
            assign w_all_lo = ~r_s2;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= w_all_hi & ~r_level;
            r_fall <= w_all_lo & r_level;
            if (w_all_hi) begin
                r_level <= 1'b1;
            end else if (w_all_lo) begin
                r_level <= 1'b0;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/sccb_responder.sv
`default_nettype none
// ============================================================================
// Module   : sccb_responder
// Brief    : SCCB target answering 3-phase writes and 2-phase reads, with a
//            small register file and a write strobe towards the fabric.
// Revision : 1.0
// ============================================================================
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [SCCB_ID_W-1:0] DEV_ADDR  = SCCB_DEF_ID,
    parameter int                   REG_DEPTH = 64,
    parameter int                   FILT_LEN  = 3
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   sio_c_in,
    input  logic                   sio_d_in,
    output logic                   sio_d_oe,
    output logic                   wr_strobe,
    output logic [SCCB_SUB_W-1:0]  wr_subaddr,
    output logic [SCCB_DATA_W-1:0] wr_data,
    output logic                   busy,
    input  logic [SCCB_SUB_W-1:0]  cfg_rd_addr,
    output logic [SCCB_DATA_W-1:0] cfg_rd_data
);

    localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;

    sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk   (clk),
        .nrst  (nrst),
        .pad   (sio_c_in),
        .level (w_scl),
        .rise  (w_scl_rise),
        .fall  (w_scl_fall)
    );

    sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk   (clk),
        .nrst  (nrst),
        .pad   (sio_d_in),
        .level (w_sda),
        .rise  (w_sda_rise),
        .fall  (w_sda_fall)
    );

    sccb_state_t              r_state, w_state_n;
    logic [2:0]               r_cnt, w_cnt_n;
    logic [6:0]               r_shift, w_shift_n;
    logic [SCCB_DATA_W-1:0]   r_obyte, w_obyte_n;
    logic [SCCB_SUB_W-1:0]    r_ptr, w_ptr_n;
    logic                     r_oe, w_oe_n;
    logic                     r_busy, w_busy_n;
    logic                     r_strobe, w_strobe_n;
    logic [SCCB_SUB_W-1:0]    r_wsub, w_wsub_n;
    logic [SCCB_DATA_W-1:0]   r_wdata, w_wdata_n;
    logic                     w_we;
    logic [SCCB_DATA_W-1:0]   r_regs [REG_DEPTH];

    logic                     w_start, w_stop;
    logic [SCCB_DATA_W-1:0]   w_byte;
    logic [SCCB_SUB_W-1:0]    w_ptr_inc;
    logic [SCCB_DATA_W-1:0]   w_rd_cur, w_rd_nxt;

    function automatic logic in_range(input logic [SCCB_SUB_W-1:0] a);
        return {16'd0, a} < 32'(REG_DEPTH);
    endfunction

    assign w_start   = w_sda_fall & w_scl;
    assign w_stop    = w_sda_rise & w_scl;
    assign w_byte    = {r_shift, w_sda};
    assign w_ptr_inc = r_ptr + 16'd1;
    assign w_rd_cur  = in_range(r_ptr)     ? r_regs[r_ptr[AW-1:0]]     : '0;
    assign w_rd_nxt  = in_range(w_ptr_inc) ? r_regs[w_ptr_inc[AW-1:0]] : '0;

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_shift_n  = r_shift;
        w_obyte_n  = r_obyte;
        w_ptr_n    = r_ptr;
        w_oe_n     = r_oe;
        w_busy_n   = r_busy;
        w_strobe_n = 1'b0;
        w_wsub_n   = r_wsub;
        w_wdata_n  = r_wdata;
        w_we       = 1'b0;

        if (w_start) begin
            w_state_n = ST_DEV;
            w_cnt_n   = 3'd0;
            w_oe_n    = 1'b0;
        end else if (w_stop) begin
            w_state_n = ST_IDLE;
            w_cnt_n   = 3'd0;
            w_oe_n    = 1'b0;
            w_busy_n  = 1'b0;
        end else begin
            case (r_state)
                ST_DEV, ST_SUB_H, ST_SUB_L, ST_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_n = w_byte[6:0];
                        w_cnt_n   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            if (r_state == ST_DEV) begin
                                if (w_byte[7:1] == DEV_ADDR) begin
                                    w_state_n = ST_DEV_ACK;
                                    w_busy_n  = 1'b1;
                                end else begin
                                    w_state_n = ST_IGNORE;
                                    w_busy_n  = 1'b0;
                                end
                            end else if (r_state == ST_SUB_H) begin
                                w_ptr_n   = {w_byte, r_ptr[7:0]};
                                w_state_n = ST_SUB_H_ACK;
                            end else if (r_state == ST_SUB_L) begin
                                w_ptr_n   = {r_ptr[15:8], w_byte};
                                w_state_n = ST_SUB_L_ACK;
                            end else begin
                                w_strobe_n = 1'b1;
                                w_wsub_n   = r_ptr;
                                w_wdata_n  = w_byte;
                                w_we       = in_range(r_ptr);
                                w_ptr_n    = w_ptr_inc;
                                w_state_n  = ST_WDATA_ACK;
                            end
                        end
                    end
                end

                // First SCL fall pulls SDA low, the next one (end of 9th clock) moves on.
                ST_DEV_ACK, ST_SUB_H_ACK, ST_SUB_L_ACK, ST_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_oe) begin
                            w_oe_n = 1'b1;
                        end else begin
                            w_oe_n  = 1'b0;
                            w_cnt_n = 3'd0;
                            case (r_state)
                                ST_DEV_ACK: begin
                                    if (r_shift[0]) begin
                                        w_state_n = ST_RDATA;
                                        w_obyte_n = w_rd_cur;
                                        w_oe_n    = ~w_rd_cur[7];
                                    end else begin
                                        w_state_n = ST_SUB_H;
                                    end
                                end
                                ST_SUB_H_ACK: w_state_n = ST_SUB_L;
                                default:      w_state_n = ST_WDATA;
                            endcase
                        end
                    end
                end

                ST_RDATA: begin
                    if (w_scl_rise) begin
                        w_cnt_n = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_state_n = ST_RDATA_ACK;
                        end
                    end else if (w_scl_fall) begin
                        w_oe_n = ~r_obyte[3'd7 - r_cnt];
                    end
                end

                ST_RDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_oe_n = 1'b0;
                    end else if (w_scl_rise) begin
                        if (!w_sda) begin
                            w_ptr_n   = w_ptr_inc;
                            w_obyte_n = w_rd_nxt;
                            w_cnt_n   = 3'd0;
                            w_state_n = ST_RDATA;
                        end else begin
                            w_state_n = ST_IGNORE;
                        end
                    end
                end

                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 3'd0;
            r_shift  <= '0;
            r_obyte  <= '0;
            r_ptr    <= '0;
            r_oe     <= 1'b0;
            r_busy   <= 1'b0;
            r_strobe <= 1'b0;
            r_wsub   <= '0;
            r_wdata  <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_shift  <= w_shift_n;
            r_obyte  <= w_obyte_n;
            r_ptr    <= w_ptr_n;
            r_oe     <= w_oe_n;
            r_busy   <= w_busy_n;
            r_strobe <= w_strobe_n;
            r_wsub   <= w_wsub_n;
            r_wdata  <= w_wdata_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[r_ptr[AW-1:0]] <= w_byte;
        end
    end

    always_comb begin
        cfg_rd_data = '0;
        if (in_range(cfg_rd_addr)) begin
            cfg_rd_data = r_regs[cfg_rd_addr[AW-1:0]];
        end
    end

    assign sio_d_oe   = r_oe;
    assign wr_strobe  = r_strobe;
    assign wr_subaddr = r_wsub;
    assign wr_data    = r_wdata;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sccb_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sccb_responder
// Brief    : Self-checking bench: SCCB initiator model plus register-file and
//            write-strobe reference model for sccb_responder.
// Revision : 1.0
// ============================================================================
module tb_sccb_responder;
    import sccb_pkg::*;

    localparam int H = 10;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic [15:0] cfg_rd_addr = 16'd0;
    logic        sio_d_in;
    logic        sio_d_oe, wr_strobe, busy;
    logic [15:0] wr_subaddr;
    logic [7:0]  wr_data, cfg_rd_data;

    assign sio_d_in = sda_m & ~sio_d_oe;

    always #20 clk = ~clk;

    sccb_responder #(.DEV_ADDR(7'h3C), .REG_DEPTH(64), .FILT_LEN(3)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .sio_c_in    (scl_m),
        .sio_d_in    (sio_d_in),
        .sio_d_oe    (sio_d_oe),
        .wr_strobe   (wr_strobe),
        .wr_subaddr  (wr_subaddr),
        .wr_data     (wr_data),
        .busy        (busy),
        .cfg_rd_addr (cfg_rd_addr),
        .cfg_rd_data (cfg_rd_data)
    );

    int          checks = 0;
    int          errors = 0;
    bit          quiet = 1'b0;
    bit          exp_busy = 1'b0;
    logic [7:0]  mreg [64];
    logic [15:0] exp_sub_q [$];
    logic [7:0]  exp_dat_q [$];
    logic [15:0] exp_s;
    logic [7:0]  exp_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mrd(input logic [15:0] a);
        return (a < 16'd64) ? mreg[a[5:0]] : 8'h00;
    endfunction

    task automatic model_write(input logic [15:0] sub, input logic [7:0] d);
        exp_sub_q.push_back(sub);
        exp_dat_q.push_back(d);
        if (sub < 16'd64) mreg[sub[5:0]] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mreg[i] = 8'h00;
        exp_sub_q.delete();
        exp_dat_q.delete();
    endtask

    // Strobes are checked against the queue on every cycle; idle outputs only when the bus is quiet.
    always @(negedge clk) begin
        if (nrst) begin
            if (wr_strobe) begin
                if (exp_sub_q.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    exp_s = exp_sub_q.pop_front();
                    exp_d = exp_dat_q.pop_front();
                    chk("wr_subaddr", 32'(wr_subaddr), 32'(exp_s));
                    chk("wr_data", 32'(wr_data), 32'(exp_d));
                end
            end
            if (quiet) begin
                chk("idle_oe", 32'(sio_d_oe), 32'd0);
                chk("idle_busy", 32'(busy), 32'd0);
                chk("cfg_rd_data", 32'(cfg_rd_data), 32'(mrd(cfg_rd_addr)));
            end
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wcyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bit_slot(input logic drv, input bit glitch,
                            output logic pad, output logic oe_s, output logic busy_s);
        wcyc(3);
        sda_m = drv;
        if (glitch) begin
            wcyc(1);
            scl_m = 1'b1;
            wcyc(2);
            scl_m = 1'b0;
            wcyc(H - 6);
        end else begin
            wcyc(H - 3);
        end
        scl_m = 1'b1;
        wcyc(H / 2);
        pad    = sio_d_in;
        oe_s   = sio_d_oe;
        busy_s = busy;
        wcyc(H - H / 2);
        scl_m = 1'b0;
    endtask

    task automatic bus_start();
        quiet = 1'b0;
        if (!scl_m) begin
            wcyc(3);
            sda_m = 1'b1;
            wcyc(H - 3);
            scl_m = 1'b1;
            wcyc(H);
        end
        sda_m = 1'b0;
        wcyc(H);
        scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        wcyc(3);
        sda_m = 1'b0;
        wcyc(H - 3);
        scl_m = 1'b1;
        wcyc(H);
        sda_m = 1'b1;
        wcyc(H);
        quiet = 1'b1;
        repeat (16) begin
            cfg_rd_addr = 16'($urandom_range(0, 79));
            wcyc(1);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input bit glitch);
        logic p, o, bz;
        for (int i = 7; i >= 0; i--) begin
            bit_slot(b[i], glitch && (i == 4), p, o, bz);
            chk("data_bit_oe", 32'(o), 32'd0);
        end
        bit_slot(1'b1, 1'b0, p, o, bz);
        chk("ack_oe", 32'(o), 32'(exp_ack));
        chk("ack_busy", 32'(bz), 32'(exp_busy));
    endtask

    task automatic recv_byte(input logic [7:0] exp, input logic m_ack);
        logic p, o, bz;
        for (int i = 7; i >= 0; i--) begin
            bit_slot(1'b1, 1'b0, p, o, bz);
            chk("rd_bit", 32'(p), 32'(exp[i]));
        end
        bit_slot(~m_ack, 1'b0, p, o, bz);
        chk("rd_release", 32'(o), 32'd0);
    endtask

    task automatic partial_bits(input logic [7:0] b, input int n);
        logic p, o, bz;
        for (int i = 0; i < n; i++) begin
            bit_slot(b[7 - i], 1'b0, p, o, bz);
            chk("partial_oe", 32'(o), 32'd0);
        end
    endtask

    task automatic set_ptr(input logic [15:0] sub);
        bus_start();
        exp_busy = 1'b1;
        send_byte(8'h78, 1'b1, 1'b0);
        send_byte(sub[15:8], 1'b1, 1'b0);
        send_byte(sub[7:0], 1'b1, 1'b0);
    endtask

    task automatic wr_txn(input logic [15:0] sub, input logic [23:0] bytes, input int n);
        logic [15:0] p;
        logic [7:0]  d;
        p = sub;
        set_ptr(sub);
        for (int i = 0; i < n; i++) begin
            d = bytes[8*i +: 8];
            model_write(p, d);
            send_byte(d, 1'b1, 1'b0);
            p = p + 16'd1;
        end
        bus_stop();
    endtask

    task automatic rd_txn(input logic [15:0] sub, input int n);
        logic [15:0] p;
        p = sub;
        set_ptr(sub);
        bus_stop();
        bus_start();
        exp_busy = 1'b1;
        send_byte(8'h79, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) begin
            recv_byte(mrd(p), (i < n - 1));
            p = p + 16'd1;
        end
        bus_stop();
    endtask

    task automatic check_rd(input string name, input logic [15:0] a, input logic [7:0] exp);
        cfg_rd_addr = a;
        wcyc(1);
        chk(name, 32'(cfg_rd_data), 32'(exp));
    endtask

    initial begin
        logic [15:0] sub;
        model_clear();
        wcyc(5);
        chk("rst_oe", 32'(sio_d_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_subaddr", 32'(wr_subaddr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        check_rd("rst_reg", 16'h0012, 8'h00);
        nrst = 1'b1;
        wcyc(10);

        // 1: basic 3-phase write
        wr_txn(16'h0012, 24'h0000A5, 1);
        check_rd("t1_reg12", 16'h0012, 8'hA5);

        // 2: pointer set, then read back with NA
        set_ptr(16'h0012);
        bus_stop();
        bus_start();
        send_byte(8'h79, 1'b1, 1'b0);
        recv_byte(8'hA5, 1'b0);
        bus_stop();

        // 3: foreign device ID
        bus_start();
        exp_busy = 1'b0;
        send_byte(8'h42, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'h5A, 1'b0, 1'b0);
        bus_stop();
        check_rd("t3_reg12", 16'h0012, 8'hA5);

        // 4: burst crossing the end of the register file
        wr_txn(16'h003F, 24'h002211, 2);
        check_rd("t4_reg3f", 16'h003F, 8'h11);
        check_rd("t4_reg40", 16'h0040, 8'h00);

        // 5a: STOP inside a data byte
        set_ptr(16'h0020);
        partial_bits(8'hFF, 5);
        bus_stop();
        check_rd("t5_reg20", 16'h0020, 8'h00);

        // 5b: repeated START inside SUB_L
        bus_start();
        exp_busy = 1'b1;
        send_byte(8'h78, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        partial_bits(8'hFF, 3);
        bus_start();
        send_byte(8'h78, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h21, 1'b1, 1'b0);
        model_write(16'h0021, 8'h5A);
        send_byte(8'h5A, 1'b1, 1'b0);
        bus_stop();
        check_rd("t5_reg21", 16'h0021, 8'h5A);

        // 6a: SCL glitch inside the device byte
        bus_start();
        exp_busy = 1'b1;
        send_byte(8'h78, 1'b1, 1'b1);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h30, 1'b1, 1'b0);
        model_write(16'h0030, 8'h3C);
        send_byte(8'h3C, 1'b1, 1'b0);
        bus_stop();
        check_rd("t6_reg30", 16'h0030, 8'h3C);

        // 6b: reset while shifting out 0xA5 (bit 6 is 0, so SDA is driven)
        set_ptr(16'h0012);
        bus_stop();
        bus_start();
        send_byte(8'h79, 1'b1, 1'b0);
        begin
            logic p, o, bz;
            bit_slot(1'b1, 1'b0, p, o, bz);
            chk("t6_bit7_oe", 32'(o), 32'd0);
        end
        wcyc(H);
        scl_m = 1'b1;
        wcyc(H / 2);
        chk("t6_bit6_oe", 32'(sio_d_oe), 32'd1);
        nrst = 1'b0;
        wcyc(1);
        chk("t6_rst_oe_1clk", 32'(sio_d_oe), 32'd0);
        model_clear();
        wcyc(3);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_strobe", 32'(wr_strobe), 32'd0);
        chk("t6_rst_subaddr", 32'(wr_subaddr), 32'd0);
        chk("t6_rst_data", 32'(wr_data), 32'd0);
        check_rd("t6_rst_reg12", 16'h0012, 8'h00);
        nrst = 1'b1;
        wcyc(2);
        scl_m = 1'b0;
        wcyc(H);
        bus_stop();

        // Randomized writes and reads against the model
        for (int t = 0; t < 10; t++) begin
            if ($urandom_range(0, 9) == 0) sub = 16'hFFFF;
            else sub = 16'($urandom_range(0, 79));
            if ($urandom_range(0, 1) == 1) wr_txn(sub, 24'($urandom()), $urandom_range(1, 3));
            else rd_txn(sub, $urandom_range(1, 3));
        end

        wcyc(5);
        chk("strobe_queue_empty", 32'(exp_sub_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
